// File: rtl/jt5205_interpolnx.sv
// jt5205_interpolnx -- N-times linear interpolator for the JT5205 ADPCM output.
//
// Takes decoder-rate samples on cen_in and emits N-1 evenly spaced
// intermediate points per input period on cen_out, where N = 2**LOG2N.
// With interp_en=0 the block is a zero-order hold with zero latency.
//
// Parameters
//   DW     sample width (signed two's complement)
//   LOG2N  interpolation factor exponent, 1..4
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cen_in     one-cycle strobe, new sample on din
//   cen_out    one-cycle strobe at output rate
//   interp_en  1 = linear interpolation, 0 = zero-order hold
//   din        signed input sample
//   dout       signed interpolated sample
//   dout_stb   one-cycle pulse while dout shows a freshly written value
//   overrun    sticky: cen_out arrived with phase already at N-1
//   underrun   sticky: cen_in arrived before phase reached N-1
module jt5205_interpolnx #(
  parameter int DW    = 12,
  parameter int LOG2N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen_in,
  input  logic                 cen_out,
  input  logic                 interp_en,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout,
  output logic                 dout_stb,
  output logic                 overrun,
  output logic                 underrun
);

  localparam int N  = 1 << LOG2N;
  localparam int AW = DW + LOG2N + 1;
  localparam logic [LOG2N-1:0] PH_LAST = LOG2N'(N - 1);

  logic signed [DW-1:0]  cur_q,   cur_d;
  logic signed [DW:0]    delta_q, delta_d;
  logic signed [AW-1:0]  acc_q,   acc_d;
  logic [LOG2N-1:0]      phase_q, phase_d;
  logic signed [DW-1:0]  dout_q,  dout_d;
  logic                  stb_q,   stb_d;
  logic                  ovr_q,   ovr_d;
  logic                  und_q,   und_d;
  // Mode latched at cen_in so a toggle only takes effect at the period edge.
  logic                  mode_q,  mode_d;
  // No period exists before the first cen_in, so that one cannot underrun.
  logic                  started_q, started_d;

  logic signed [DW:0]    delta_new;
  logic signed [AW-1:0]  acc_base;   // cur * N, the period's point 0
  logic signed [AW-1:0]  acc_step;   // acc + delta, the next point
  logic signed [AW-1:0]  acc_shr;

  always_comb begin
    delta_new = {din[DW-1], din} - {cur_q[DW-1], cur_q};
    acc_base  = AW'(cur_q) <<< LOG2N;
    acc_step  = acc_q + AW'(delta_q);
    // Arithmetic shift floors; the result is bounded by the two endpoint
    // samples so truncation back to DW bits never wraps.
    acc_shr   = acc_step >>> LOG2N;
  end

  always_comb begin
    cur_d     = cur_q;
    delta_d   = delta_q;
    acc_d     = acc_q;
    phase_d   = phase_q;
    dout_d    = dout_q;
    stb_d     = 1'b0;
    ovr_d     = ovr_q;
    und_d     = und_q;
    mode_d    = mode_q;
    started_d = started_q;

    if (cen_in) begin
      // cen_in wins over a coincident cen_out; that cen_out is dropped.
      mode_d    = interp_en;
      started_d = 1'b1;
      stb_d     = 1'b1;
      cur_d     = din;
      if (interp_en) begin
        acc_d   = acc_base;
        delta_d = delta_new;
        phase_d = '0;
        dout_d  = cur_q;          // one input period of latency
        if (started_q && phase_q != PH_LAST) und_d = 1'b1;
      end else begin
        acc_d   = AW'(din) <<< LOG2N;
        delta_d = '0;
        phase_d = PH_LAST;
        dout_d  = din;            // zero-order hold, no latency
      end
    end else if (cen_out && mode_q) begin
      if (phase_q != PH_LAST) begin
        acc_d   = acc_step;
        phase_d = phase_q + LOG2N'(1);
        dout_d  = acc_shr[DW-1:0];
        stb_d   = 1'b1;
      end else begin
        // Hold the last point rather than extrapolating past the target.
        ovr_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q     <= '0;
      delta_q   <= '0;
      acc_q     <= '0;
      phase_q   <= '0;
      dout_q    <= '0;
      stb_q     <= 1'b0;
      ovr_q     <= 1'b0;
      und_q     <= 1'b0;
      mode_q    <= 1'b1;
      started_q <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      delta_q   <= delta_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      dout_q    <= dout_d;
      stb_q     <= stb_d;
      ovr_q     <= ovr_d;
      und_q     <= und_d;
      mode_q    <= mode_d;
      started_q <= started_d;
    end
  end

  assign dout     = dout_q;
  assign dout_stb = stb_q;
  assign overrun  = ovr_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_jt5205_interpolnx.sv
module tb_jt5205_interpolnx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: LOG2N=2
  logic ci_a = 0, co_a = 0, en_a = 1;
  logic signed [11:0] din_a = '0, dout_a;
  logic stb_a, ov_a, un_a;
  // DUT B: LOG2N=4
  logic ci_b = 0, co_b = 0, en_b = 1;
  logic signed [11:0] din_b = '0, dout_b;
  logic stb_b, ov_b, un_b;

  jt5205_interpolnx #(.DW(12), .LOG2N(2)) u_a (
    .clk(clk), .rst_n(rst_n), .cen_in(ci_a), .cen_out(co_a), .interp_en(en_a),
    .din(din_a), .dout(dout_a), .dout_stb(stb_a), .overrun(ov_a), .underrun(un_a));

  jt5205_interpolnx #(.DW(12), .LOG2N(4)) u_b (
    .clk(clk), .rst_n(rst_n), .cen_in(ci_b), .cen_out(co_b), .interp_en(en_b),
    .din(din_b), .dout(dout_b), .dout_stb(stb_b), .overrun(ov_b), .underrun(un_b));

  typedef struct {
    bit ci, co, en;
    int din;
    int dout;
    bit stb, ov, un;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input bit ci, input bit co, input bit en, input int din,
                     input int dout, input bit stb, input bit ov, input bit un);
    vec_t v;
    v.ci = ci; v.co = co; v.en = en; v.din = din;
    v.dout = dout; v.stb = stb; v.ov = ov; v.un = un;
    vq.push_back(v);
  endtask

  // Inputs are driven 1 time unit after a posedge, outputs checked 1 unit after the next.
  task automatic step_b(input bit ci, input bit co, input int din);
    ci_b = ci; co_b = co; din_b = 12'(din);
    @(posedge clk); #1;
    ci_b = 0; co_b = 0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_dout", int'(dout_a), 0);
    chk("rst_stb", int'(stb_a), 0);
    chk("rst_ovr", int'(ov_a), 0);
    chk("rst_und", int'(un_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //  ci co en  din     dout   stb ov un
    // ramp 0 -> 400
    add(1, 0, 1, 0,       0,     1, 0, 0);
    add(0, 1, 1, 0,       0,     1, 0, 0);
    add(0, 1, 1, 0,       0,     1, 0, 0);
    add(0, 1, 1, 0,       0,     1, 0, 0);
    add(1, 0, 1, 400,     0,     1, 0, 0);
    add(0, 1, 1, 0,       100,   1, 0, 0);
    add(0, 0, 1, 0,       100,   0, 0, 0);   // idle: hold, no strobe
    add(0, 1, 1, 0,       200,   1, 0, 0);
    add(0, 1, 1, 0,       300,   1, 0, 0);
    add(1, 0, 1, 100,     400,   1, 0, 0);
    add(0, 1, 1, 0,       325,   1, 0, 0);
    add(0, 1, 1, 0,       250,   1, 0, 0);
    add(0, 1, 1, 0,       175,   1, 0, 0);
    // negative floor: 100 -> -101
    add(1, 0, 1, -101,    100,   1, 0, 0);
    add(0, 1, 1, 0,       49,    1, 0, 0);
    add(0, 1, 1, 0,       -1,    1, 0, 0);
    add(0, 1, 1, 0,       -51,   1, 0, 0);
    add(1, 0, 1, 2047,    -101,  1, 0, 0);
    add(0, 1, 1, 0,       436,   1, 0, 0);
    add(0, 1, 1, 0,       973,   1, 0, 0);
    add(0, 1, 1, 0,       1510,  1, 0, 0);
    // full-scale swing 2047 -> -2048
    add(1, 0, 1, -2048,   2047,  1, 0, 0);
    add(0, 1, 1, 0,       1023,  1, 0, 0);
    add(0, 1, 1, 0,       -1,    1, 0, 0);
    add(0, 1, 1, 0,       -1025, 1, 0, 0);
    // -2048 -> 0 with five cen_out: overrun, hold at point 3
    add(1, 0, 1, 0,       -2048, 1, 0, 0);
    add(0, 1, 1, 0,       -1536, 1, 0, 0);
    add(0, 1, 1, 0,       -1024, 1, 0, 0);
    add(0, 1, 1, 0,       -512,  1, 0, 0);
    add(0, 1, 1, 0,       -512,  0, 1, 0);
    add(0, 1, 1, 0,       -512,  0, 1, 0);
    // short period: underrun
    add(1, 0, 1, 800,     0,     1, 1, 0);
    add(0, 1, 1, 0,       200,   1, 1, 0);
    add(1, 0, 1, 0,       800,   1, 1, 1);
    // bypass
    add(1, 0, 0, -7,      -7,    1, 1, 1);
    add(0, 1, 0, 0,       -7,    0, 1, 1);
    add(0, 1, 0, 0,       -7,    0, 1, 1);
    // back to interpolation; en drop mid-period keeps the period going
    add(1, 0, 1, 20,      -7,    1, 1, 1);
    add(0, 1, 0, 0,       -1,    1, 1, 1);
    add(0, 1, 1, 0,       6,     1, 1, 1);
    add(0, 1, 1, 0,       13,    1, 1, 1);
    // start of a period for the reset test
    add(1, 0, 1, 400,     20,    1, 1, 1);
    add(0, 1, 1, 0,       115,   1, 1, 1);

    foreach (vq[i]) begin
      ci_a = vq[i].ci; co_a = vq[i].co; en_a = vq[i].en; din_a = 12'(vq[i].din);
      @(posedge clk); #1;
      ci_a = 0; co_a = 0; en_a = 1;
      chk($sformatf("v%0d_dout", i), int'(dout_a), vq[i].dout);
      chk($sformatf("v%0d_stb", i), int'(stb_a), int'(vq[i].stb));
      chk($sformatf("v%0d_ovr", i), int'(ov_a), int'(vq[i].ov));
      chk($sformatf("v%0d_und", i), int'(un_a), int'(vq[i].un));
    end

    // async reset mid-period, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("arst_dout", int'(dout_a), 0);
    chk("arst_ovr", int'(ov_a), 0);
    chk("arst_und", int'(un_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LOG2N=4: ramp from the reset value 0 up to 1600
    step_b(1, 0, 1600);
    chk("b_pt0", int'(dout_b), 0);
    chk("b_un_first", int'(un_b), 0);
    for (int k = 1; k < 16; k++) begin
      step_b(0, 1, 0);
      chk($sformatf("b_pt%0d", k), int'(dout_b), 100 * k);
    end
    // coincident cen_in + cen_out: cen_in wins, no flag
    step_b(1, 1, 0);
    chk("b_coin_dout", int'(dout_b), 1600);
    chk("b_coin_ovr", int'(ov_b), 0);
    chk("b_coin_und", int'(un_b), 0);
    step_b(0, 1, 0);
    chk("b_after_coin", int'(dout_b), 1500);
    // sixteenth cen_out in this period overruns
    for (int k = 2; k < 16; k++) step_b(0, 1, 0);
    chk("b_last_pt", int'(dout_b), 100);
    chk("b_no_ovr", int'(ov_b), 0);
    step_b(0, 1, 0);
    chk("b_ovr", int'(ov_b), 1);
    chk("b_ovr_hold", int'(dout_b), 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
